// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 keypad scanner with debounce and hex-entry shift register
// Optional auto-repeat of a held key when KEYPAD_REPEAT_EN is defined.
module keypad_scan #(
    parameter int SCAN_MAX     = 99999,
    parameter int DEBOUNCE_CNT = 4,
    parameter int REPEAT_TICKS = 250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic [15:0] value
);

    localparam int PW = (SCAN_MAX > 0) ? $clog2(SCAN_MAX + 1) : 1;
    localparam int CW = (DEBOUNCE_CNT > 0) ? $clog2(DEBOUNCE_CNT + 1) : 1;

    if (SCAN_MAX < 0 || DEBOUNCE_CNT < 1 || REPEAT_TICKS < 1) begin : g_bad_params
        $error("keypad_scan: SCAN_MAX >= 0, DEBOUNCE_CNT >= 1 and REPEAT_TICKS >= 1 required");
    end

    typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_RELEASE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [1:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [3:0]      pat_q, pat_d;
    logic [3:0]      col_s1_q, col_s2_q;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;
    logic [15:0]     value_q, value_d;
    logic            tick, accept, emit;
    logic [3:0]      col_s;

    function automatic logic one_low(input logic [3:0] p);
        return (p == 4'b0111) || (p == 4'b1011) || (p == 4'b1101) || (p == 4'b1110);
    endfunction

    // col[3] is column 0, col[0] is column 3
    function automatic logic [1:0] col_idx(input logic [3:0] p);
        case (p)
            4'b0111: return 2'd0;
            4'b1011: return 2'd1;
            4'b1101: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    assign col_s   = col_s2_q;
    assign tick    = (presc_q == PW'(SCAN_MAX));
    assign presc_d = tick ? '0 : presc_q + PW'(1);
    assign cnt_inc = cnt_q + CW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_SCAN;
            presc_q     <= '0;
            idx_q       <= 2'd0;
            cnt_q       <= '0;
            pat_q       <= 4'hF;
            col_s1_q    <= 4'hF;
            col_s2_q    <= 4'hF;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            value_q     <= 16'h0000;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            pat_q       <= pat_d;
            col_s1_q    <= col;
            col_s2_q    <= col_s1_q;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            value_q     <= value_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        accept  = 1'b0;
        if (tick) begin
            case (state_q)
                S_SCAN: begin
                    if (one_low(col_s)) begin
                        pat_d   = col_s;
                        cnt_d   = '0;
                        state_d = S_DEBOUNCE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
                S_DEBOUNCE: begin
                    if (col_s == pat_q) begin
                        if (cnt_inc == CW'(DEBOUNCE_CNT)) begin
                            accept  = 1'b1;
                            cnt_d   = '0;
                            state_d = S_RELEASE;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = S_SCAN;
                    end
                end
                S_RELEASE: begin
                    if (col_s == 4'hF) begin
                        if (cnt_inc == CW'(DEBOUNCE_CNT)) begin
                            cnt_d   = '0;
                            state_d = S_SCAN;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: state_d = S_SCAN;
            endcase
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);

    logic [RW-1:0] rep_q, rep_d, rep_inc;
    logic          rep_fire;

    assign rep_inc = rep_q + RW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end

    // Repeat interval restarts at acceptance and whenever the held pattern drops
    always_comb begin
        rep_d    = rep_q;
        rep_fire = 1'b0;
        if (tick) begin
            if (accept) begin
                rep_d = '0;
            end else if (state_q == S_RELEASE && col_s == pat_q) begin
                if (rep_inc == RW'(REPEAT_TICKS)) begin
                    rep_fire = 1'b1;
                    rep_d    = '0;
                end else begin
                    rep_d = rep_inc;
                end
            end else begin
                rep_d = '0;
            end
        end
    end

    assign emit = accept | rep_fire;
`else
    assign emit = accept;
`endif

    always_comb begin
        row         = ~(4'b1000 >> idx_q);
        key_valid_d = emit;
        key_code_d  = emit ? {idx_q, col_idx(pat_q)} : key_code_q;
        if (clr) begin
            value_d = 16'h0000;
        end else if (emit) begin
            value_d = {value_q[11:0], idx_q, col_idx(pat_q)};
        end else begin
            value_d = value_q;
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign value     = value_q;

endmodule
